// File: rtl/microwave_pkg.sv
// Shared types and output-decode tables for the microwave controllers.
// Lamp and bell outputs are looked up in these tables, indexed by the state encoding.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COOK  = 3'd1,
    PAUSE = 3'd2,
    HOLD  = 3'd3,
    BELL  = 3'd4,
    OPEN  = 3'd5
  } mw_state_t;

  // Bit n set = output active while state encoding equals n.
  localparam logic [7:0] LIGHT_ON = 8'b0010_0110;  // COOK, PAUSE, OPEN
  localparam logic [7:0] BELL_ON  = 8'b0001_0000;  // BELL

endpackage

// File: rtl/microwave_timer_if.sv
// Front-panel and actuator bundle between the appliance logic and microwave_timer.
interface microwave_timer_if #(
  parameter int TIME_W     = 8,
  parameter int PWR_LEVELS = 4
);
  localparam int PW = $clog2(PWR_LEVELS);

  logic              door;
  logic              start;
  logic              cancel;
  logic              time_load;
  logic [TIME_W-1:0] time_in;
  logic [PW-1:0]     power;
  logic              heat;
  logic              light;
  logic              bell;
  logic [TIME_W-1:0] remaining;

  modport master (
    output door, start, cancel, time_load, time_in, power,
    input  heat, light, bell, remaining
  );

  modport slave (
    input  door, start, cancel, time_load, time_in, power,
    output heat, light, bell, remaining
  );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every DIV enabled cycles.
// The count holds while en is low, so a partial period survives a pause.
module tick_prescaler #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign tick = en & (cnt == LAST);
endmodule

// File: rtl/microwave_timer.sv
// Microwave controller: cook-time countdown, power duty cycling, timed bell and
// door-pause handling with optional auto-resume.
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int TIME_W      = 8,
  parameter int TICK_DIV    = 1000,
  parameter int PWR_LEVELS  = 4,
  parameter int BELL_TICKS  = 3,
  parameter int AUTO_RESUME = 1
) (
  input logic            clk,
  input logic            nrst,
  microwave_timer_if.slave mw
);
  localparam int            PW        = $clog2(PWR_LEVELS);
  localparam int            BW        = $clog2(BELL_TICKS + 1);
  localparam logic [PW-1:0] PWR_TOP   = PW'(PWR_LEVELS - 1);
  localparam logic [BW-1:0] BELL_LAST = BW'(BELL_TICKS - 1);

  mw_state_t         state, state_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic [PW-1:0]     pwm_q, pwm_d;
  logic [PW-1:0]     pwr_q, pwr_d;
  logic [BW-1:0]     bell_q, bell_d;
  logic              tick, ps_en, ps_clr;

  // An open door freezes the prescaler in COOK so the fractional second is kept.
  assign ps_en  = ((state == COOK) && !mw.door) || (state == BELL);
  assign ps_clr = (((state == IDLE) || (state == HOLD)) && (state_d == COOK)) ||
                  ((state == COOK) && (state_d == BELL));

  tick_prescaler #(.DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .nrst (nrst),
    .en   (ps_en),
    .clr  (ps_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      rem_q  <= '0;
      pwm_q  <= '0;
      pwr_q  <= '0;
      bell_q <= '0;
    end else begin
      state  <= state_d;
      rem_q  <= rem_d;
      pwm_q  <= pwm_d;
      pwr_q  <= pwr_d;
      bell_q <= bell_d;
    end
  end

  always_comb begin
    state_d = state;
    rem_d   = rem_q;
    pwm_d   = pwm_q;
    pwr_d   = pwr_q;
    bell_d  = bell_q;
    case (state)
      IDLE: begin
        if (mw.door) state_d = OPEN;
        else if (mw.cancel) rem_d = '0;
        else begin
          // start sees the pre-load remaining; a same-cycle load still lands.
          if (mw.start && (rem_q != '0)) begin
            state_d = COOK;
            pwr_d   = mw.power;
            pwm_d   = '0;
          end
          if (mw.time_load) rem_d = mw.time_in;
        end
      end
      OPEN: begin
        if (!mw.door) state_d = IDLE;
        if (mw.cancel)         rem_d = '0;
        else if (mw.time_load) rem_d = mw.time_in;
      end
      COOK: begin
        if (mw.door) state_d = PAUSE;
        else if (mw.cancel) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (tick) begin
          pwm_d = (pwm_q == PWR_TOP) ? '0 : pwm_q + PW'(1);
          if (rem_q == TIME_W'(1)) begin
            state_d = BELL;
            rem_d   = '0;
            bell_d  = '0;
          end else begin
            rem_d = rem_q - TIME_W'(1);
          end
        end
      end
      PAUSE: begin
        if (!mw.door) state_d = (AUTO_RESUME != 0) ? COOK : HOLD;
        else if (mw.cancel) begin
          state_d = OPEN;
          rem_d   = '0;
        end
      end
      HOLD: begin
        if (mw.door) state_d = PAUSE;
        else if (mw.cancel) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (mw.start && (rem_q != '0)) begin
          state_d = COOK;
          pwr_d   = mw.power;
          pwm_d   = '0;
        end
      end
      BELL: begin
        if (mw.door)        state_d = OPEN;
        else if (mw.cancel) state_d = IDLE;
        else if (tick) begin
          if (bell_q == BELL_LAST) state_d = IDLE;
          else                     bell_d  = bell_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mw.light     = LIGHT_ON[state];
  assign mw.bell      = BELL_ON[state];
  assign mw.heat      = (state == COOK) && (pwm_q <= pwr_q);
  assign mw.remaining = rem_q;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer: one auto-resume instance, one hold instance.
module tb_microwave_timer;
  import microwave_pkg::*;

  localparam int TW = 8, DIV = 4, PL = 4, BT = 2;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  microwave_timer_if #(.TIME_W(TW), .PWR_LEVELS(PL)) mw ();
  microwave_timer_if #(.TIME_W(TW), .PWR_LEVELS(PL)) mh ();

  microwave_timer #(.TIME_W(TW), .TICK_DIV(DIV), .PWR_LEVELS(PL), .BELL_TICKS(BT),
                    .AUTO_RESUME(1)) dut (.clk(clk), .nrst(nrst), .mw(mw.slave));
  microwave_timer #(.TIME_W(TW), .TICK_DIV(DIV), .PWR_LEVELS(PL), .BELL_TICKS(BT),
                    .AUTO_RESUME(0)) dut_h (.clk(clk), .nrst(nrst), .mw(mh.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    mw.door = 0; mw.start = 0; mw.cancel = 0; mw.time_load = 0; mw.time_in = '0; mw.power = '0;
    mh.door = 0; mh.start = 0; mh.cancel = 0; mh.time_load = 0; mh.time_in = '0; mh.power = '0;
    step(2);
    chk("rst_state", dut.state, IDLE);
    chk("rst_heat",  mw.heat, 0);
    chk("rst_light", mw.light, 0);
    chk("rst_bell",  mw.bell, 0);
    chk("rst_rem",   mw.remaining, 0);
    nrst = 1;
    step(1);

    // 3 s at full power
    mw.time_in = 3; mw.power = 3; mw.time_load = 1;
    step(1);
    mw.time_load = 0;
    chk("load3", mw.remaining, 3);
    mw.start = 1;
    step(1);
    mw.start = 0;
    for (int k = 0; k < 12; k++) begin
      chk("s1_state", dut.state, COOK);
      chk("s1_heat",  mw.heat, 1);
      chk("s1_rem",   mw.remaining, 3 - k / 4);
      step(1);
    end
    for (int k = 0; k < 8; k++) begin
      chk("s1_bell",  mw.bell, 1);
      chk("s1_blite", mw.light, 0);
      step(1);
    end
    chk("s1_idle",   dut.state, IDLE);
    chk("s1_bell0",  mw.bell, 0);
    chk("s1_rem0",   mw.remaining, 0);

    // power 1 over 2 s: on, on
    mw.time_in = 2; mw.power = 1; mw.time_load = 1;
    step(1);
    mw.time_load = 0; mw.start = 1;
    step(1);
    mw.start = 0;
    for (int k = 0; k < 8; k++) begin
      chk("p1_heat", mw.heat, 1);
      step(1);
    end
    chk("p1_bell", dut.state, BELL);
    step(8);
    chk("p1_idle", dut.state, IDLE);

    // power 0 over 8 s: one tick in four
    mw.time_in = 8; mw.power = 0; mw.time_load = 1;
    step(1);
    mw.time_load = 0; mw.start = 1;
    step(1);
    mw.start = 0;
    for (int k = 0; k < 32; k++) begin
      chk("p0_heat", mw.heat, ((k / 4) % 4) == 0);
      step(1);
    end
    chk("p0_bell", dut.state, BELL);
    step(8);
    chk("p0_idle", dut.state, IDLE);

    // door pause with auto-resume, prescaler resumes mid-second
    mw.time_in = 3; mw.power = 3; mw.time_load = 1;
    step(1);
    mw.time_load = 0; mw.start = 1;
    step(1);
    mw.start = 0;
    step(5);
    chk("ar_rem_pre", mw.remaining, 2);
    mw.door = 1;
    step(1);
    chk("ar_pause", dut.state, PAUSE);
    chk("ar_light", mw.light, 1);
    chk("ar_heat",  mw.heat, 0);
    chk("ar_rem",   mw.remaining, 2);
    step(3);
    chk("ar_hold_rem", mw.remaining, 2);
    mw.door = 0;
    step(1);
    chk("ar_cook", dut.state, COOK);
    chk("ar_rem_r0", mw.remaining, 2);
    step(2);
    chk("ar_rem_r2", mw.remaining, 2);
    step(1);
    chk("ar_rem_r3", mw.remaining, 1);
    step(4);
    chk("ar_bell", dut.state, BELL);
    step(8);
    chk("ar_idle", dut.state, IDLE);

    // same with AUTO_RESUME=0 on second instance
    mh.time_in = 3; mh.power = 3; mh.time_load = 1;
    step(1);
    mh.time_load = 0; mh.start = 1;
    step(1);
    mh.start = 0;
    step(5);
    mh.door = 1;
    step(1);
    chk("h_pause", dut_h.state, PAUSE);
    mh.door = 0;
    step(1);
    chk("h_hold",  dut_h.state, HOLD);
    chk("h_light", mh.light, 0);
    chk("h_heat",  mh.heat, 0);
    chk("h_rem",   mh.remaining, 2);
    step(2);
    chk("h_stay",  dut_h.state, HOLD);
    mh.start = 1;
    step(1);
    mh.start = 0;
    chk("h_cook",  dut_h.state, COOK);
    chk("h_clight", mh.light, 1);
    step(3);
    chk("h_rem_r3", mh.remaining, 2);
    step(1);
    chk("h_rem_r4", mh.remaining, 1);
    mh.cancel = 1;
    step(1);
    mh.cancel = 0;
    chk("h_cancel", dut_h.state, IDLE);
    chk("h_crem",   mh.remaining, 0);

    // cancel, ignored load, start with zero time
    mw.time_in = 5; mw.power = 3; mw.time_load = 1;
    step(1);
    mw.time_load = 0; mw.start = 1;
    step(1);
    mw.start = 0;
    mw.time_in = 9; mw.time_load = 1;
    step(1);
    mw.time_load = 0;
    chk("c_noload", mw.remaining, 5);
    mw.cancel = 1;
    step(1);
    mw.cancel = 0;
    chk("c_idle", dut.state, IDLE);
    chk("c_rem",  mw.remaining, 0);
    mw.start = 1;
    step(1);
    mw.start = 0;
    chk("z_idle", dut.state, IDLE);
    chk("z_heat", mw.heat, 0);

    // cancel + start together
    mw.time_in = 4; mw.time_load = 1;
    step(1);
    mw.time_load = 0;
    chk("cs_load", mw.remaining, 4);
    mw.cancel = 1; mw.start = 1;
    step(1);
    mw.cancel = 0; mw.start = 0;
    chk("cs_idle", dut.state, IDLE);
    chk("cs_rem",  mw.remaining, 0);

    // load + start together with old remaining 0
    mw.time_in = 2; mw.time_load = 1; mw.start = 1;
    step(1);
    mw.time_load = 0; mw.start = 0;
    chk("ls_idle", dut.state, IDLE);
    chk("ls_rem",  mw.remaining, 2);

    // door on the final tick
    mw.time_in = 1; mw.time_load = 1;
    step(1);
    mw.time_load = 0; mw.start = 1;
    step(1);
    mw.start = 0;
    step(3);
    mw.door = 1;
    step(1);
    chk("ft_pause", dut.state, PAUSE);
    chk("ft_rem",   mw.remaining, 1);
    mw.door = 0;
    step(1);
    chk("ft_cook", dut.state, COOK);
    step(1);
    chk("ft_bell", mw.bell, 1);
    chk("ft_rem0", mw.remaining, 0);

    // async reset mid-bell
    step(2);
    chk("rb_bell", mw.bell, 1);
    #2 nrst = 0;
    #1;
    chk("rb_state", dut.state, IDLE);
    chk("rb_bell0", mw.bell, 0);
    chk("rb_light", mw.light, 0);
    chk("rb_heat",  mw.heat, 0);
    chk("rb_rem",   mw.remaining, 0);
    step(1);
    nrst = 1;
    step(1);
    mw.time_in = 2; mw.time_load = 1;
    step(1);
    mw.time_load = 0; mw.start = 1;
    step(1);
    mw.start = 0;
    chk("pr_cook", dut.state, COOK);
    chk("pr_rem",  mw.remaining, 2);
    chk("pr_heat", mw.heat, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/microwave_timer.md
# microwave_timer

Parametrised microwave controller with an integrated cook-time countdown, power-level duty cycling, timed bell and configurable resume-after-door behaviour. It drives the same `heat`/`light`/`bell` actuator outputs as the existing single-mode controller. It adds time loading, cancel and a remaining-time readout for the front-panel display logic. It is the controller instance at the top of the appliance design.

## Interface
- `TIME_W`, 8: width of cook-time counter, in seconds.
- `TICK_DIV`, 1000: clk cycles per one-second tick; ≥2.
- `PWR_LEVELS`, 4: number of power levels; ≥2; `PW = $clog2(PWR_LEVELS)`.
- `BELL_TICKS`, 3: bell duration in ticks; ≥1.
- `AUTO_RESUME`, 1: 1 = closing the door during a pause resumes cooking; 0 = go to `HOLD` and wait for `start`.

Ports:
- `clk`, in, 1: clock.
- `nrst`, in, 1: reset, asynchronous, active-low.
- `door`, in, 1: 1 = door open.
- `start`, in, 1: start or resume request, level-sampled each cycle.
- `cancel`, in, 1: abort, which clears the remaining time.
- `time_load`, in, 1: load `time_in` into the remaining-time counter.
- `time_in`, in, TIME_W: cook time in seconds.
- `power`, in, PW: power level; latched on entry to `COOK` from `IDLE` or `HOLD`.
- `heat`, out, 1: magnetron enable.
- `light`, out, 1: cavity lamp.
- `bell`, out, 1: bell drive.
- `remaining`, out, TIME_W: seconds left.

## Operation
States are `IDLE`, `COOK`, `PAUSE`, `HOLD`, `BELL`, `OPEN`.

Priority each cycle: door > cancel > tick/expiry > start/time_load.

Transitions:
- `IDLE`
  - door → `OPEN`.
  - cancel → stay, remaining := 0.
  - start & remaining≠0 → `COOK`.
  - time_load → remaining := time_in.
- `OPEN`
  - !door → `IDLE`.
  - cancel → remaining := 0.
  - time_load is accepted.
- `COOK`
  - door → `PAUSE`; remaining and prescaler hold.
  - cancel → `IDLE`, remaining := 0.
  - tick with remaining==1 → `BELL`, remaining := 0.
  - tick otherwise → remaining −1.
- `PAUSE`
  - cancel → `OPEN`, remaining := 0.
  - !door → `COOK` if AUTO_RESUME=1, else `HOLD`.
- `HOLD`
  - door → `PAUSE`.
  - cancel → `IDLE`, remaining := 0.
  - start → `COOK`, re-latching power.
- `BELL`
  - door → `OPEN`.
  - cancel → `IDLE`.
  - after BELL_TICKS ticks → `IDLE`.

Rules:
- time_load is ignored in `COOK`, `PAUSE`, `HOLD` and `BELL`.
- start with remaining==0 is ignored.

Outputs are a combinational decode of the registered state and counters:
- `light` = 1 in `COOK`, `PAUSE`, `OPEN`.
- `bell` = 1 in `BELL` only.
- `heat` = `COOK` & (pwm_cnt ≤ power_q).
- pwm_cnt counts 0..PWR_LEVELS−1 and advances on each tick in `COOK`; it resets to 0 on entry to `COOK` from `IDLE`/`HOLD`.
- At power = PWR_LEVELS−1, heat is continuous in `COOK`. At power 0, heat is on for 1 of PWR_LEVELS ticks.

Prescaler:
- Counts 0..TICK_DIV−1 in `COOK` and `BELL`.
- tick = 1 for one cycle when the count is TICK_DIV−1; the count then wraps to 0.
- Cleared on entry to `COOK` from `IDLE`/`HOLD` and on entry to `BELL`.
- Held in `PAUSE`, so a fractional second is preserved across door opening.

Bell counter: cleared on entry to `BELL`, incremented on tick.

## Timing
- Reset values: state `IDLE`, remaining 0, heat/light/bell 0, all counters 0, power_q 0. Reset mid-cook forces these immediately, since reset is asynchronous.
- State transitions take effect on the clk edge after the input is sampled. Outputs follow in the same cycle as the new state, with no added latency.
- Cook of N seconds: `COOK` lasts N·TICK_DIV cycles of uninterrupted cooking. `BELL` lasts BELL_TICKS·TICK_DIV cycles.
- Simultaneous events:
  - door rising on the same cycle as the final tick → `PAUSE` with remaining=1.
  - cancel together with start in `IDLE` → no cook.
  - time_load together with start in `IDLE` → start is evaluated with the old remaining; the new value is loaded.

## Structure
- Package `microwave_pkg` holds the state enum `mw_state_t` and the output-decode constants. The existing controller reuses this package.
- Sub-module `tick_prescaler` (parameter DIV; ports clk, nrst, en, clr, tick).
- Remaining-time, pwm and bell counters stay in the top module.

## Test plan
Bench parameters: TICK_DIV=4, PWR_LEVELS=4, BELL_TICKS=2.
- Load 3, start, power=3 → `COOK` for 12 cycles with heat continuous; remaining goes 3→2→1→0; bell for 8 cycles; then `IDLE` with bell=0.
- Load 2, power=1 → heat pattern over ticks: on, on, then `BELL`. Load 8, power=0 → heat on 1 tick in every 4.
- Door opens at cycle 5 of a 3 s cook → `PAUSE`, light=1, heat=0, remaining=2 held. Door closes with AUTO_RESUME=1 → `COOK`; the prescaler continues from 1.
- Same scenario with AUTO_RESUME=0 → `HOLD` with light=0. Start → `COOK`.
- Cancel in `COOK` with remaining=5 → `IDLE`, remaining=0. Start with remaining=0 stays `IDLE`. time_load in `COOK` is ignored.
- nrst asserted mid-`BELL` → all outputs 0 and state `IDLE` asynchronously; normal operation after release.
